dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_txq.sv | 47 ++++
 rtl/dmem_responder.sv | 85 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO addresses, TXSTAT bit positions and address-decode type for dmem_responder
package dmem_pkg;
  localparam logic [15:0] MMIO_HI = 16'hFFFF;
  localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_TXSTAT = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_CYCLE = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_HALT = 32'hFFFF_000C;
  localparam int TXSTAT_FULL = 0;
  localparam int TXSTAT_EMPTY = 1;
  localparam int TXSTAT_OVF = 2;
  localparam int TXSTAT_CNT_LSB = 8;
  typedef enum logic [2:0] {SEL_RAM, SEL_TXDATA, SEL_TXSTAT, SEL_CYCLE, SEL_HALT, SEL_NONE} sel_e;
  function automatic sel_e mmio_sel(input logic [29:0] w);
    return w == ADDR_TXDATA[31:2] ? SEL_TXDATA :
           w == ADDR_TXSTAT[31:2] ? SEL_TXSTAT :
           w == ADDR_CYCLE[31:2]  ? SEL_CYCLE  :
           w == ADDR_HALT[31:2]   ? SEL_HALT   : SEL_NONE;
  endfunction
endpackage

// File: rtl/dmem_txq.sv
// dmem_txq: byte sync FIFO; ports clk, reset, push_i/din_i in, pop_i in, dout_o head (0 when empty), full_o/empty_o/count_o status; a push on a full queue is accepted when the same edge pops
module dmem_txq
  import dmem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [7:0]                 din_i,
  input  logic                       pop_i,
  output logic [7:0]                 dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] buf_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic pop_ok, push_ok;
  always_comb begin
    empty_o = cnt_q == '0;
    full_o = cnt_q == (AW+1)'(DEPTH);
    pop_ok = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_ok);
    dout_o = empty_o ? 8'h00 : buf_q[rd_q];
    count_o = cnt_q;
    rd_d = pop_ok ? rd_q + AW'(1) : rd_q;
    wr_d = push_ok ? wr_q + AW'(1) : wr_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && push_ok) buf_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: core data-memory responder (RAM + TX queue/TXSTAT/CYCLE/HALT MMIO); ports clk, reset, dmem_we/addr/wd in, dmem_rd out, tx_valid/tx_data/tx_ready console, halt and bus_err sticky flags; define DMEM_BOUNDS_CHECK_EN to trap out-of-range RAM accesses instead of aliasing
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int TXQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wd,
  output logic [31:0] dmem_rd,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic        bus_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(TXQ_DEPTH) + 1;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] cycle_q, cycle_d, txstat;
  logic halt_q, halt_d, ovf_q, ovf_d, bus_err_q, bus_err_d;
  logic is_mmio, oob, push, full, empty, unused_ok;
  logic [AW-1:0] idx;
  logic [CW-1:0] count;
  sel_e sel;
  assign is_mmio = dmem_addr[31:16] == MMIO_HI;
  assign idx = dmem_addr[AW+1:2];
  assign unused_ok = ^dmem_addr[1:0];
`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = !is_mmio && dmem_addr[31:AW+2] != '0;
`else
  assign oob = 1'b0;
`endif
  always_comb begin
    sel = is_mmio ? mmio_sel(dmem_addr[31:2]) : oob ? SEL_NONE : SEL_RAM;
    push = dmem_we && sel == SEL_TXDATA;
    txstat = '0;
    txstat[TXSTAT_FULL] = full;
    txstat[TXSTAT_EMPTY] = empty;
    txstat[TXSTAT_OVF] = ovf_q;
    txstat[TXSTAT_CNT_LSB +: 8] = 8'(count);
    dmem_rd = sel == SEL_RAM    ? mem_q[idx] :
              sel == SEL_TXSTAT ? txstat :
              sel == SEL_CYCLE  ? cycle_q :
              sel == SEL_HALT   ? {31'b0, halt_q} : 32'h0;
    cycle_d = cycle_q + 32'd1;
    halt_d = halt_q | (dmem_we && sel == SEL_HALT && dmem_wd[0]);
    // a full queue only drops the push if the sink is not taking the head this edge
    ovf_d = (dmem_we && sel == SEL_TXSTAT) ? 1'b0 : ovf_q | (push && full && !tx_ready);
    bus_err_d = bus_err_q | (dmem_we && oob);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      halt_q <= 1'b0;
      ovf_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      halt_q <= halt_d;
      ovf_q <= ovf_d;
      bus_err_q <= bus_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && dmem_we && sel == SEL_RAM) mem_q[idx] <= dmem_wd;
  end
  dmem_txq #(.DEPTH(TXQ_DEPTH)) u_txq (
    .clk(clk),
    .reset(reset),
    .push_i(push),
    .din_i(dmem_wd[7:0]),
    .pop_i(tx_ready),
    .dout_o(tx_data),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
  assign tx_valid = !empty;
  assign halt = halt_q;
  assign bus_err = bus_err_q;
endmodule
